// File: rtl/fact_seq.sv
// ============================================================================
// Module   : fact_seq
// Purpose  : Computes N! by sequencing a 64x64->128 signed multiplier.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fact_seq #(
    parameter int DW = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [DW-1:0]   n,
    output logic            busy,
    output logic            done,
    output logic            overflow,
    output logic [2*DW-1:0] result,
    output logic            mul_start,
    output logic            mul_clear,
    output logic [DW-1:0]   mul_a,
    output logic [DW-1:0]   mul_b,
    input  logic            mul_done,
    input  logic [2*DW-1:0] mul_result
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_MSTART = 3'd2,
        S_MWAIT  = 3'd3,
        S_MCLR   = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    state_t          r_state, w_state;
    logic [2*DW-1:0] r_acc, w_acc;
    logic [DW-1:0]   r_i, w_i;
    logic [DW-1:0]   r_n, w_n;
    logic            r_busy, w_busy;
    logic            r_done, w_done;
    logic            r_ovf, w_ovf;
    logic [2*DW-1:0] r_result, w_result;
    logic            r_mstart, w_mstart;
    logic            r_mclear, w_mclear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_INIT;
            r_acc    <= {{(2*DW-1){1'b0}}, 1'b1};
            r_i      <= '0;
            r_n      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_result <= '0;
            r_mstart <= 1'b0;
            r_mclear <= 1'b1;
        end else begin
            r_state  <= w_state;
            r_acc    <= w_acc;
            r_i      <= w_i;
            r_n      <= w_n;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_ovf    <= w_ovf;
            r_result <= w_result;
            r_mstart <= w_mstart;
            r_mclear <= w_mclear;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_acc    = r_acc;
        w_i      = r_i;
        w_n      = r_n;
        w_busy   = r_busy;
        w_done   = r_done;
        w_ovf    = r_ovf;
        w_result = r_result;
        w_mstart = 1'b0;
        w_mclear = 1'b0;

        case (r_state)
            S_INIT: begin
                w_state = S_IDLE;
            end
            S_IDLE, S_FIN: begin
                if (start) begin
                    w_n   = n;
                    w_acc = {{(2*DW-1){1'b0}}, 1'b1};
                    w_i   = DW'(2);
                    w_ovf = 1'b0;
                    w_done = 1'b0;
                    if (n <= DW'(1)) begin
                        w_state  = S_FIN;
                        w_result = {{(2*DW-1){1'b0}}, 1'b1};
                        w_done   = 1'b1;
                    end else begin
                        w_busy   = 1'b1;
                        w_state  = S_MSTART;
                        w_mstart = 1'b1;
                    end
                end
            end
            S_MSTART: begin
                w_state = S_MWAIT;
            end
            S_MWAIT: begin
                if (mul_done) begin
                    w_acc    = mul_result;
                    w_state  = S_MCLR;
                    w_mclear = 1'b1;
                end
            end
            S_MCLR: begin
                // The next operand must stay below 2^(DW-1) so it is not read as negative.
                if (r_i == r_n) begin
                    w_state  = S_FIN;
                    w_result = r_acc;
                    w_done   = 1'b1;
                    w_busy   = 1'b0;
                end else if (|r_acc[2*DW-1:DW-1]) begin
                    w_state  = S_FIN;
                    w_result = r_acc;
                    w_done   = 1'b1;
                    w_busy   = 1'b0;
                    w_ovf    = 1'b1;
                end else begin
                    w_i      = r_i + DW'(1);
                    w_state  = S_MSTART;
                    w_mstart = 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign overflow  = r_ovf;
    assign result    = r_result;
    assign mul_start = r_mstart;
    assign mul_clear = r_mclear;
    assign mul_a     = r_acc[DW-1:0];
    assign mul_b     = r_i;

endmodule

`default_nettype wire

// File: tb/tb_fact_seq.sv
// ============================================================================
// Module   : tb_fact_seq
// Purpose  : Directed self-checking bench for fact_seq with a multiplier stub.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fact_seq;

    localparam int DW  = 64;
    localparam int LAT = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [DW-1:0]   n = '0;
    logic            busy, done, overflow;
    logic [2*DW-1:0] result;
    logic            mul_start, mul_clear;
    logic [DW-1:0]   mul_a, mul_b;
    logic            m_done = 1'b0;
    logic [2*DW-1:0] m_res = '0;
    logic            m_busy = 1'b0;
    int              m_cnt = 0;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] exp_a [64];
    logic [DW-1:0] exp_b [64];
    int  exp_cnt = 0;
    int  pidx = 0;
    int  clr_cnt = 0;
    bit  active = 1'b0;

    fact_seq #(.DW(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .n(n),
        .busy(busy), .done(done), .overflow(overflow), .result(result),
        .mul_start(mul_start), .mul_clear(mul_clear),
        .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(m_done), .mul_result(m_res)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: fixed latency, sticky done until cleared.
    always @(posedge clk) begin
        if (mul_clear) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (mul_start) begin
            m_busy <= 1'b1;
            m_cnt  <= LAT;
            m_res  <= {{DW{1'b0}}, mul_a} * {{DW{1'b0}}, mul_b};
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_done <= 1'b1;
                m_busy <= 1'b0;
            end
            m_cnt <= m_cnt - 1;
        end
    end

    task automatic chk(input string name, input logic [2*DW-1:0] act, input logic [2*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Factorial with the early-stop rule; records the expected operand pairs.
    function automatic void model(input logic [DW-1:0] nn, output logic [2*DW-1:0] res,
                                  output bit ovf, output int cnt);
        logic [2*DW-1:0] acc;
        acc = 1;
        cnt = 0;
        ovf = 1'b0;
        if (nn >= 2) begin
            for (int k = 2; k <= 64; k++) begin
                exp_a[cnt] = acc[DW-1:0];
                exp_b[cnt] = DW'(k);
                cnt++;
                acc = acc * k;
                if (DW'(k) == nn) break;
                if (acc >= (128'd1 << 63)) begin
                    ovf = 1'b1;
                    break;
                end
            end
        end
        res = acc;
    endfunction

    always @(negedge clk) begin
        if (active) begin
            if (mul_start) begin
                if (pidx < exp_cnt) begin
                    chk($sformatf("mul_a[%0d]", pidx), mul_a, exp_a[pidx]);
                    chk($sformatf("mul_b[%0d]", pidx), mul_b, exp_b[pidx]);
                end else begin
                    chk("extra_mul_start", pidx, exp_cnt);
                end
                pidx++;
            end
            if (mul_clear) clr_cnt++;
            if (done) chk("busy_with_done", busy, 0);
        end
    end

    task automatic run(input logic [DW-1:0] nn, input string tag, output logic [2*DW-1:0] mres);
        bit mo;
        int mc;
        int t;
        model(nn, mres, mo, mc);
        exp_cnt = mc;
        pidx    = 0;
        clr_cnt = 0;
        active  = 1'b1;
        @(negedge clk);
        n = nn;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (nn >= 2) chk({tag, "_busy_after_accept"}, busy, 1);
        t = 0;
        while (!done && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_result"}, result, mres);
        chk({tag, "_overflow"}, overflow, mo);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_pulses"}, pidx, mc);
        chk({tag, "_clears"}, clr_cnt, mc);
        active = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_mstart"}, mul_start, 0);
        chk({tag, "_mclear"}, mul_clear, 1);
        chk({tag, "_mul_a"}, mul_a, 1);
        chk({tag, "_mul_b"}, mul_b, 0);
    endtask

    initial begin
        logic [2*DW-1:0] r;
        int t;
        #2 reset = 1'b1;
        #1 chk_reset_vals("por");
        @(posedge clk);
        @(posedge clk);
        #1 chk("mclear_in_reset", mul_clear, 1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 chk("mclear_after_release", mul_clear, 0);

        run(0, "n0", r);
        chk("n0_literal", result, 1);
        run(1, "n1", r);
        run(5, "n5", r);
        chk("n5_literal", result, 128'd120);
        chk("n5_model_literal", r, 128'd120);
        run(20, "n20", r);
        chk("n20_literal", result, 128'd2432902008176640000);
        run(21, "n21", r);
        chk("n21_literal", result, 128'd51090942171709440000);
        chk("n21_model_literal", r, 128'd51090942171709440000);
        run(22, "n22", r);
        chk("n22_literal", result, 128'd51090942171709440000);
        chk("n22_ovf_literal", overflow, 1);
        chk("n22_pulses_literal", pidx, 20);

        // Abort n=10 during the third multiply wait.
        begin
            bit mo;
            int mc;
            model(10, r, mo, mc);
            exp_cnt = mc;
            pidx    = 0;
            clr_cnt = 0;
            active  = 1'b1;
            @(negedge clk);
            n = 10;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            t = 0;
            while (pidx < 3 && t < 2000) begin
                @(negedge clk);
                t++;
            end
            chk("abort_reached_third", pidx, 3);
            @(posedge clk);
            #2 reset = 1'b1;
            active = 1'b0;
            #1 chk_reset_vals("abort");
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            @(posedge clk);
            #1 chk("abort_mclear_release", mul_clear, 0);
        end
        run(3, "n3_after_abort", r);
        chk("n3_literal", result, 128'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
